// File: rtl/gals_write_arbiter_pkg.sv
// Shared types and helpers for the producer-side write arbiter.
package gals_write_arbiter_pkg;

    localparam int DATA_W_DEFAULT = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_STALL = 2'd2
    } state_t;

    // Index arithmetic modulo n for 3-bit requester indices (offset < n).
    function automatic logic [2:0] wrap_idx(input logic [2:0] base, input int offset, input int n);
        int sum;
        sum = int'(base) + offset;
        if (sum >= n) begin
            sum = sum - n;
        end
        return 3'(sum);
    endfunction

endpackage

// File: rtl/gals_write_arbiter_rr_priority_pick.sv
// Round-robin pick: first requester at or after start, wrapping modulo NUM_REQ.
module gals_write_arbiter_rr_priority_pick
    import gals_write_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [2:0]         start,
    output logic [2:0]         winner,
    output logic               found
);

    logic [NUM_REQ-1:0] rotated;

    // Rotate so that bit 0 is the requester at start.
    assign rotated = NUM_REQ'({req, req} >> start);

    // Scan from the far end so the nearest requester to start is the one kept.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rotated[i]) begin
                found  = 1'b1;
                winner = wrap_idx(start, i, NUM_REQ);
            end
        end
    end

endmodule

// File: rtl/gals_write_arbiter.sv
// Shares the buffer write port among NUM_REQ producers with round-robin
// grants, bounded bursts and stall on buffer_full.
//
//  state    | meaning
//  ---------+----------------------------------------------------------
//  ST_IDLE  | no owner; arbitrate from rr_ptr when any req is high
//  ST_GRANT | owner holds the port; word written whenever not full
//  ST_STALL | owner holds the port; buffer full, no writes
module gals_write_arbiter
    import gals_write_arbiter_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = DATA_W_DEFAULT,
    parameter int BURST_MAX = 4
) (
    input  logic                      clock_1,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic                      buffer_full,
    output logic [NUM_REQ-1:0]        ack,
    output logic [DATA_W-1:0]         data_1,
    output logic                      data_1_en,
    output logic                      grant_valid,
    output logic [2:0]                grant_id
);

    localparam logic [3:0] BURST_LAST = 4'(BURST_MAX - 1);

    state_t                    state;
    logic [2:0]                owner;
    logic [2:0]                rr_ptr;
    logic [3:0]                burst_cnt;
    logic                      owner_req;
    logic [2:0]                next_ptr;
    logic [2:0]                pick_start;
    logic [2:0]                pick_winner;
    logic                      pick_found;
    logic                      release_now;
    logic [NUM_REQ*DATA_W-1:0] data_shifted;

    assign grant_id     = owner;
    assign owner_req    = |(req & (NUM_REQ'(1) << owner));
    assign next_ptr     = wrap_idx(owner, 1, NUM_REQ);
    assign data_shifted = req_data >> (32'(owner) * DATA_W);

    // Write port and acknowledge are driven in the same cycle so the
    // producer advances exactly when the buffer captures the word.
    assign data_1_en = (state == ST_GRANT) & owner_req & ~buffer_full;
    assign data_1    = data_1_en ? data_shifted[DATA_W-1:0] : '0;
    assign ack       = data_1_en ? (NUM_REQ'(1) << owner) : '0;

    // One picker serves both idle arbitration and handoff on release.
    assign pick_start = (state == ST_IDLE) ? rr_ptr : next_ptr;

    gals_write_arbiter_rr_priority_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req    (req),
        .start  (pick_start),
        .winner (pick_winner),
        .found  (pick_found)
    );

    // Owner gives up the port when it drops req or finishes its last burst word.
    always_comb begin
        release_now = 1'b0;
        if (state == ST_GRANT) begin
            release_now = ~owner_req | (data_1_en & (burst_cnt == BURST_LAST));
        end else if (state == ST_STALL) begin
            release_now = ~owner_req;
        end
    end

    // Grant state machine with direct handoff on release.
    always_ff @(posedge clock_1 or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            owner       <= '0;
            rr_ptr      <= '0;
            burst_cnt   <= '0;
            grant_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_found) begin
                        owner       <= pick_winner;
                        burst_cnt   <= '0;
                        state       <= ST_GRANT;
                        grant_valid <= 1'b1;
                    end
                end
                ST_GRANT, ST_STALL: begin
                    if (release_now) begin
                        rr_ptr    <= next_ptr;
                        burst_cnt <= '0;
                        if (pick_found) begin
                            owner       <= pick_winner;
                            state       <= ST_GRANT;
                            grant_valid <= 1'b1;
                        end else begin
                            state       <= ST_IDLE;
                            grant_valid <= 1'b0;
                        end
                    end else if (state == ST_GRANT) begin
                        if (buffer_full) begin
                            state <= ST_STALL;
                        end else begin
                            burst_cnt <= burst_cnt + 4'd1;
                        end
                    end else if (!buffer_full) begin
                        state <= ST_GRANT;
                    end
                end
                default: begin
                    state       <= ST_IDLE;
                    grant_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
